// File: rtl/mem_cmd_responder_pkg.sv
// ============================================================================
//  Module      : mem_cmd_responder_pkg
//  Description : Shared opcodes, bus IDs, command-word field offsets and the
//                responder state encoding for the memory command responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_cmd_responder_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_HASH  = 2'b11;

    localparam logic [1:0] MEM_ID = 2'b00;
    localparam logic [1:0] AES_ID = 2'b01;
    localparam logic [1:0] SHA_ID = 2'b10;

    // Command word: {addr, rsvd[1:0], dest_id[1:0], src_id[1:0], opcode[1:0]}
    localparam int CMD_OPCODE_LSB = 0;
    localparam int CMD_SRC_LSB    = 2;
    localparam int CMD_DEST_LSB   = 4;
    localparam int CMD_RSVD_LSB   = 6;
    localparam int CMD_ADDR_LSB   = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MEM_RD = 3'd1,
        S_TX     = 3'd2,
        S_RX     = 3'd3,
        S_MEM_WR = 3'd4,
        S_ACK    = 3'd5
    } resp_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_cmd_responder_beat_counter.sv
// ============================================================================
//  Module      : beat_counter
//  Description : Byte index within a block transfer, with clear, increment
//                and a last-byte flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_counter #(
    parameter int BLOCK_BYTES = 32,
    parameter int CNTW        = $clog2(BLOCK_BYTES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [CNTW-1:0] cnt,
    output logic            last
);
    import mem_cmd_responder_pkg::*;

    localparam logic [CNTW-1:0] C_LAST = CNTW'(BLOCK_BYTES - 1);

    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_cmd_responder.sv
// ============================================================================
//  Module      : mem_cmd_responder
//  Description : Decodes accelerator bus commands and moves one block between
//                the byte-wide memory port and the accelerator byte streams,
//                then returns a one-cycle completion ACK.
//                Option macro: MEM_CMD_RSVD_CHECK_EN discards READ/WRITE words
//                with non-zero reserved bits or equal source/destination IDs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_cmd_responder #(
    parameter int         ADDRW       = 24,
    parameter int         BLOCK_BYTES = 32,
    parameter logic [1:0] MEM_ID      = mem_cmd_responder_pkg::MEM_ID
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [ADDRW+7:0] cmd_data,
    output logic             cmd_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic [2:0]       ack_out
);
    import mem_cmd_responder_pkg::*;

    localparam int CNTW = $clog2(BLOCK_BYTES);

`ifdef MEM_CMD_RSVD_CHECK_EN
    localparam logic C_RSVD_CHECK = 1'b1;
`else
    localparam logic C_RSVD_CHECK = 1'b0;
`endif

    resp_state_t      r_state;
    resp_state_t      w_state_nxt;
    logic [ADDRW-1:0] r_addr;
    logic [7:0]       r_byte;

    logic [CNTW-1:0]  w_cnt;
    logic             w_last;
    logic             w_cnt_clr;
    logic             w_cnt_inc;

    logic [1:0]       w_opcode;
    logic [1:0]       w_src;
    logic [1:0]       w_dest;
    logic [1:0]       w_rsvd;
    logic [ADDRW-1:0] w_cmd_addr;
    logic             w_fmt_ok;
    logic             w_svc_rd;
    logic             w_svc_wr;
    logic             w_accept_svc;

    assign w_opcode   = cmd_data[CMD_OPCODE_LSB +: 2];
    assign w_src      = cmd_data[CMD_SRC_LSB    +: 2];
    assign w_dest     = cmd_data[CMD_DEST_LSB   +: 2];
    assign w_rsvd     = cmd_data[CMD_RSVD_LSB   +: 2];
    assign w_cmd_addr = cmd_data[CMD_ADDR_LSB   +: ADDRW];

    assign w_fmt_ok = !C_RSVD_CHECK || ((w_rsvd == 2'b00) && (w_dest != w_src));

    // Only a READ sourced from us or a WRITE destined to us is serviced.
    always_comb begin
        w_svc_rd = 1'b0;
        w_svc_wr = 1'b0;
        case (w_opcode)
            OP_READ:         w_svc_rd = (w_src  == MEM_ID) && w_fmt_ok;
            OP_WRITE:        w_svc_wr = (w_dest == MEM_ID) && w_fmt_ok;
            OP_NOP, OP_HASH: ;
        endcase
    end

    assign w_accept_svc = (r_state == S_IDLE) && cmd_valid && (w_svc_rd || w_svc_wr);

    beat_counter #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_cnt_clr),
        .inc  (w_cnt_inc),
        .cnt  (w_cnt),
        .last (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_byte  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept_svc) begin
                r_addr <= w_cmd_addr;
            end
            if ((r_state == S_MEM_RD) && mem_ack) begin
                r_byte <= mem_rdata;
            end
            if ((r_state == S_RX) && rx_valid) begin
                r_byte <= rx_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        cmd_ready   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        rx_ready    = 1'b0;
        ack_out     = 3'b000;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                w_cnt_clr = w_accept_svc;
                if (cmd_valid && w_svc_rd) begin
                    w_state_nxt = S_MEM_RD;
                end else if (cmd_valid && w_svc_wr) begin
                    w_state_nxt = S_RX;
                end
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_addr + ADDRW'(w_cnt);
                if (mem_ack) begin
                    w_state_nxt = S_TX;
                end
            end
            S_TX: begin
                tx_valid = 1'b1;
                tx_data  = r_byte;
                if (tx_ready) begin
                    w_cnt_inc   = !w_last;
                    w_state_nxt = w_last ? S_ACK : S_MEM_RD;
                end
            end
            S_RX: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    w_state_nxt = S_MEM_WR;
                end
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr + ADDRW'(w_cnt);
                mem_wdata = r_byte;
                if (mem_ack) begin
                    w_cnt_inc   = !w_last;
                    w_state_nxt = w_last ? S_ACK : S_RX;
                end
            end
            S_ACK: begin
                ack_out     = {1'b1, MEM_ID};
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_cmd_responder.sv
// ============================================================================
//  Module      : tb_mem_cmd_responder
//  Description : Self-checking bench for mem_cmd_responder (BLOCK_BYTES = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_cmd_responder;
    import mem_cmd_responder_pkg::*;

    localparam int ADDRW = 24;
    localparam int NB    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic [ADDRW+7:0] cmd_data;
    logic             cmd_ready;
    logic             mem_req;
    logic             mem_we;
    logic [ADDRW-1:0] mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;
    logic             mem_ack;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic [2:0]       ack_out;

    always #5 clk = ~clk;

    mem_cmd_responder #(
        .ADDRW       (ADDRW),
        .BLOCK_BYTES (NB),
        .MEM_ID      (MEM_ID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .ack_out   (ack_out)
    );

    function automatic logic [7:0] mem_model(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h3C;
    endfunction

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  data;
    } mem_exp_t;

    typedef struct {
        logic [31:0] cmd;
        int          kind;     // 0 discard, 1 read, 2 write
        int          gap;
        int          lat;
        int          exp_lat;  // -1: latency not checked
    } vec_t;

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       n_ack = 0;
    int       last_ack_cyc = -100;
    int       mem_lat = 0;
    int       req_age = 0;
    bit       tx_rdy_en = 1'b1;
    mem_exp_t exp_mem[$];
    logic [7:0] exp_tx[$];
    mem_exp_t m_e;
    logic [7:0] m_b;
    vec_t     vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) req_age <= req_age + 1;
        else                     req_age <= 0;
    end

    assign mem_ack   = mem_req && (req_age >= mem_lat);
    assign mem_rdata = mem_ack ? mem_model(mem_addr) : 8'h00;
    assign tx_ready  = tx_rdy_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed memory access and stream beat pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_ack) begin
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_access", {1'b1, mem_we, mem_addr}, 64'h0);
                end else begin
                    m_e = exp_mem.pop_front();
                    check("mem_addr", mem_addr, m_e.addr);
                    check("mem_we", mem_we, m_e.we);
                    if (m_e.we) check("mem_wdata", mem_wdata, m_e.data);
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check("unexpected_tx_beat", {1'b1, tx_data}, 64'h0);
                end else begin
                    m_b = exp_tx.pop_front();
                    check("tx_data", tx_data, m_b);
                end
            end
            if (ack_out != 3'b000) begin
                n_ack++;
                last_ack_cyc = cyc;
                check("ack_out_value", ack_out, {1'b1, MEM_ID});
            end
        end
    end

    task automatic drive_cmd(input logic [31:0] w, output int acc);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = w;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept_timeout", ok, 1);
        @(posedge clk); #1;
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic send_rx(input int gap, input logic [7:0] base, input int nbytes);
        bit ok;
        for (int i = 0; i < nbytes; i++) begin
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            rx_valid = 1'b1;
            rx_data  = 8'(base + i);
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (rx_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("rx_handshake_timeout", ok, 1);
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_block(input int kind, input logic [23:0] a, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            if (kind == 1) begin
                exp_mem.push_back('{1'b0, 24'(a + 24'(i)), 8'h00});
                exp_tx.push_back(mem_model(24'(a + 24'(i))));
            end else if (kind == 2) begin
                exp_mem.push_back('{1'b1, 24'(a + 24'(i)), 8'(8'hA0 + i)});
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n0;
        int acc;
        bit ok;
        n0      = n_ack;
        mem_lat = v.lat;
        push_block(v.kind, v.cmd[31:8], NB);
        drive_cmd(v.cmd, acc);
        if (v.kind == 2) send_rx(v.gap, 8'hA0, NB);
        wait_idle(ok);
        check("done_timeout", ok, 1);
        if (v.kind == 0) begin
            repeat (4) begin
                @(negedge clk);
                check("discard_idle", {mem_req, rx_ready, tx_valid, cmd_ready}, 4'b0001);
            end
        end
        check("ack_count", n_ack - n0, (v.kind != 0) ? 1 : 0);
        check("exp_mem_drained", exp_mem.size(), 0);
        check("exp_tx_drained", exp_tx.size(), 0);
        if (v.exp_lat >= 0) check("ack_latency", last_ack_cyc - acc, v.exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int  acc;
        int  n0;
        bit  ok;
        logic [7:0] hold;

        vecs[0] = '{{24'h000100, 2'b00, AES_ID, MEM_ID, OP_READ},  1, 0, 0,  8};
        vecs[1] = '{{24'h000200, 2'b00, MEM_ID, AES_ID, OP_WRITE}, 2, 3, 0, -1};
        vecs[2] = '{{24'hFFFFFE, 2'b00, AES_ID, MEM_ID, OP_READ},  1, 0, 0,  8};
        vecs[3] = '{{24'h000000, 8'h53},                           0, 0, 0, -1};
        vecs[4] = '{{24'h000300, 2'b00, MEM_ID, AES_ID, OP_READ},  0, 0, 0, -1};
        vecs[5] = '{{24'h000340, 2'b00, SHA_ID, AES_ID, OP_WRITE}, 0, 0, 0, -1};
        vecs[6] = '{{24'h000100, 2'b00, MEM_ID, MEM_ID, OP_NOP},   0, 0, 0, -1};
        vecs[7] = '{{24'h000700, 2'b00, MEM_ID, SHA_ID, OP_WRITE}, 2, 0, 2, -1};
        vecs[8] = '{{24'h0007F0, 2'b00, SHA_ID, MEM_ID, OP_READ},  1, 0, 1, -1};
        vecs[9] = '{{24'h000800, 2'b00, MEM_ID, AES_ID, OP_WRITE}, 2, 0, 0,  8};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        #12;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, tx_valid, tx_data, rx_ready, ack_out}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Back-pressure: held tx beat, and a second command waiting out the transfer.
        n0        = n_ack;
        tx_rdy_en = 1'b0;
        mem_lat   = 0;
        push_block(1, 24'h000400, NB);
        drive_cmd({24'h000400, 2'b00, SHA_ID, MEM_ID, OP_READ}, acc);
        cmd_valid = 1'b1;
        cmd_data  = {24'h000000, 8'h53};
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("tx_valid_timeout", ok, 1);
        hold = tx_data;
        check("tx_first_byte", hold, mem_model(24'h000400));
        repeat (4) begin
            @(negedge clk);
            check("tx_hold", {tx_valid, tx_data}, {1'b1, mem_model(24'h000400)});
            check("cmd_ready_busy", cmd_ready, 0);
        end
        @(posedge clk); #1;
        tx_rdy_en = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("second_cmd_timeout", ok, 1);
        check("accept_after_ack", cyc - last_ack_cyc, 1);
        check("bp_ack_count", n_ack - n0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_hash_discarded", {cmd_ready, mem_req, rx_ready}, 3'b100);
        check("bp_exp_drained", exp_mem.size() + exp_tx.size(), 0);

        // Asynchronous reset while waiting for byte 2 of a WRITE.
        mem_lat = 0;
        push_block(2, 24'h000600, 2);
        drive_cmd({24'h000600, 2'b00, MEM_ID, AES_ID, OP_WRITE}, acc);
        send_rx(0, 8'hA0, 2);
        @(negedge clk);
        @(posedge clk); #2;
        check("rx_ready_before_reset", rx_ready, 1);
        rst = 1'b1;
        #1;
        check("async_reset_cmd_ready", cmd_ready, 1);
        check("async_reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, tx_valid, tx_data, rx_ready, ack_out}, 0);
        check("partial_writes_done", exp_mem.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n0  = n_ack;
        repeat (20) @(negedge clk);
        check("no_ack_after_reset", n_ack - n0, 0);
        check("idle_after_reset", {cmd_ready, mem_req, rx_ready}, 3'b100);
        run_vec('{{24'h000900, 2'b00, AES_ID, MEM_ID, OP_READ}, 1, 0, 0, 8});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
